// File: rtl/clkmux_select_ctrl.sv
//==============================================================================
// Module   : clkmux_select_ctrl
// Purpose  : Drives the glitch-free clock mux select, waits out the settle
//            window, then proves the muxed clock alive via a heartbeat.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module clkmux_select_ctrl #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int HB_EDGES       = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2,
    parameter bit RESET_SEL      = 1'b0
) (
    input  logic aclk,
    input  logic areset,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic selection,
    output logic cur_sel,
    input  logic hb_toggle,
    output logic switching,
    output logic locked,
    output logic done_pulse,
    output logic error_pulse
);

    localparam int c_settle_w = $clog2(SETTLE_CYCLES + 1);
    localparam int c_edge_w   = $clog2(HB_EDGES + 1);
    localparam int c_tmo_w    = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);
    localparam logic [c_edge_w-1:0]   c_edge_goal   = c_edge_w'(HB_EDGES);
    localparam logic [c_tmo_w-1:0]    c_tmo_last    = c_tmo_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_VERIFY = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    edge_q;
    logic [c_settle_w-1:0]   settle_q, settle_d;
    logic [c_edge_w-1:0]     edges_q, edges_d;
    logic [c_tmo_w-1:0]      tmo_q, tmo_d;
    logic                    sel_q, sel_d;
    logic                    cur_q, cur_d;
    logic                    locked_q, locked_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    w_hb_edge;
    logic                    w_accept;
    logic [c_edge_w-1:0]     w_edges_inc;
    logic [c_tmo_w-1:0]      w_tmo_inc;

    // Either heartbeat transition counts, so a divided muxed clock still works.
    assign w_hb_edge   = sync_q[SYNC_STAGES-1] ^ edge_q;
    assign w_accept    = req_valid && (state_q == S_IDLE);
    assign w_edges_inc = edges_q + c_edge_w'(w_hb_edge);
    assign w_tmo_inc   = tmo_q + c_tmo_w'(1);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= S_VERIFY;
            sync_q   <= '0;
            edge_q   <= 1'b0;
            settle_q <= '0;
            edges_q  <= '0;
            tmo_q    <= '0;
            sel_q    <= RESET_SEL;
            cur_q    <= RESET_SEL;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], hb_toggle};
            edge_q   <= sync_q[SYNC_STAGES-1];
            settle_q <= settle_d;
            edges_q  <= edges_d;
            tmo_q    <= tmo_d;
            sel_q    <= sel_d;
            cur_q    <= cur_d;
            locked_q <= locked_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        edges_d  = edges_q;
        tmo_d    = tmo_q;
        sel_d    = sel_q;
        cur_d    = cur_q;
        locked_d = locked_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    // Already running on a verified clock: acknowledge without touching the mux.
                    if ((req_sel == cur_q) && locked_q) begin
                        done_d = 1'b1;
                    end else begin
                        sel_d    = req_sel;
                        locked_d = 1'b0;
                        settle_d = '0;
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == c_settle_last) begin
                    edges_d = '0;
                    tmo_d   = '0;
                    state_d = S_VERIFY;
                end else begin
                    settle_d = settle_q + c_settle_w'(1);
                end
            end
            S_VERIFY: begin
                tmo_d   = w_tmo_inc;
                edges_d = w_edges_inc;
                if (w_edges_inc == c_edge_goal) begin
                    locked_d = 1'b1;
                    cur_d    = sel_q;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (w_tmo_inc == c_tmo_last) begin
                    locked_d = 1'b0;
                    cur_d    = sel_q;
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == S_IDLE);
    assign switching   = (state_q != S_IDLE);
    assign selection   = sel_q;
    assign cur_sel     = cur_q;
    assign locked      = locked_q;
    assign done_pulse  = done_q;
    assign error_pulse = err_q;

endmodule

`default_nettype wire

// File: tb/tb_clkmux_select_ctrl.sv
//==============================================================================
// Module   : tb_clkmux_select_ctrl
// Purpose  : Self-checking bench: scenario table, latency sequences and a
//            randomized run against an event-timed reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_clkmux_select_ctrl;

    localparam int SETTLE = 16;
    localparam int HB     = 4;
    localparam int TMO    = 1024;
    localparam int SYNC   = 2;
    localparam bit RSEL   = 1'b0;

    logic aclk      = 1'b0;
    logic areset    = 1'b1;
    logic req_valid = 1'b0;
    logic req_sel   = 1'b0;
    logic hb_toggle = 1'b0;
    logic req_ready, selection, cur_sel, switching, locked, done_pulse, error_pulse;

    clkmux_select_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .HB_EDGES      (HB),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (SYNC),
        .RESET_SEL     (RSEL)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .selection  (selection),
        .cur_sel    (cur_sel),
        .hb_toggle  (hb_toggle),
        .switching  (switching),
        .locked     (locked),
        .done_pulse (done_pulse),
        .error_pulse(error_pulse)
    );

    always #5 aclk = ~aclk;

    // Heartbeat source: toggles every hb_per control cycles, stuck when 0.
    int hb_per = 0;
    int hb_cnt = 0;
    always @(negedge aclk) begin
        if (hb_per == 0) begin
            hb_cnt = 0;
        end else begin
            hb_cnt = hb_cnt + 1;
            if (hb_cnt >= hb_per) begin
                hb_cnt    = 0;
                hb_toggle = ~hb_toggle;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: phases timed by absolute cycle deadlines.
    int            cyc       = 0;
    int            m_phase   = 2;   // 0 idle, 1 settle, 2 verify
    int            verify_at = 0;
    int            deadline  = TMO;
    int            m_edges   = 0;
    bit            m_sel     = RSEL;
    bit            m_cur     = RSEL;
    bit            m_locked  = 1'b0;
    bit            m_done    = 1'b0;
    bit            m_err     = 1'b0;
    logic [SYNC:0] hist      = '0;  // hb samples, newest at index 0

    bit saw_done, saw_err, saw_sw;

    task automatic model_edge(input bit rst, input bit v, input bit s, input bit hb);
        bit e;
        e = hist[SYNC-1] ^ hist[SYNC];
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            hist     = '0;
            m_sel    = RSEL;
            m_cur    = RSEL;
            m_locked = 1'b0;
            m_phase  = 2;
            m_edges  = 0;
            deadline = cyc + TMO;
        end else begin
            hist = {hist[SYNC-1:0], hb};
            case (m_phase)
                0: if (v) begin
                    if (s == m_cur && m_locked) begin
                        m_done = 1'b1;
                    end else begin
                        m_sel     = s;
                        m_locked  = 1'b0;
                        m_phase   = 1;
                        verify_at = cyc + 1 + SETTLE;
                    end
                end
                1: if (cyc + 1 == verify_at) begin
                    m_phase  = 2;
                    m_edges  = 0;
                    deadline = verify_at + TMO - 1;
                end
                default: begin
                    m_edges = m_edges + int'(e);
                    if (m_edges == HB) begin
                        m_done = 1'b1; m_locked = 1'b1; m_cur = m_sel; m_phase = 0;
                    end else if (cyc + 1 == deadline) begin
                        m_err = 1'b1; m_locked = 1'b0; m_cur = m_sel; m_phase = 0;
                    end
                end
            endcase
        end
        cyc = cyc + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        logic [6:0] act, exp;
        @(posedge aclk);
        #1;
        model_edge(areset, req_valid, req_sel, hb_toggle);
        exp = {m_sel, m_cur, m_locked, m_done, m_err, (m_phase == 0), (m_phase != 0)};
        act = {selection, cur_sel, locked, done_pulse, error_pulse, req_ready, switching};
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL model cycle %0d {sel,cur,lock,done,err,rdy,sw}: got %b want %b",
                     cyc, act, exp);
        end
        if (done_pulse === 1'b1)  saw_done = 1'b1;
        if (error_pulse === 1'b1) saw_err  = 1'b1;
        if (switching === 1'b1)   saw_sw   = 1'b1;
    endtask

    task automatic clear_flags();
        saw_done = 1'b0;
        saw_err  = 1'b0;
        saw_sw   = 1'b0;
    endtask

    task automatic request(input bit s);
        for (int i = 0; i < 3000 && m_phase != 0; i++) tick();
        if (m_phase != 0) chk("wait for idle", 0, 1);
        clear_flags();
        req_valid = 1'b1;
        req_sel   = s;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_result(input int budget, output int n);
        n = 0;
        while (!(saw_done || saw_err) && n < budget) begin
            tick();
            n = n + 1;
        end
        if (!(saw_done || saw_err)) chk("result within budget", 0, 1);
    endtask

    typedef struct {
        bit sel;
        int hb;
        bit exp_done;
        bit exp_err;
        bit exp_locked;
        bit exp_cur;
        bit exp_full;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        tbl[0] = '{sel: 1'b0, hb: 3, exp_done: 1'b1, exp_err: 1'b0, exp_locked: 1'b1, exp_cur: 1'b0, exp_full: 1'b1};
        tbl[1] = '{sel: 1'b1, hb: 0, exp_done: 1'b0, exp_err: 1'b1, exp_locked: 1'b0, exp_cur: 1'b1, exp_full: 1'b1};
        tbl[2] = '{sel: 1'b1, hb: 2, exp_done: 1'b1, exp_err: 1'b0, exp_locked: 1'b1, exp_cur: 1'b1, exp_full: 1'b1};
        tbl[3] = '{sel: 1'b1, hb: 0, exp_done: 1'b1, exp_err: 1'b0, exp_locked: 1'b1, exp_cur: 1'b1, exp_full: 1'b0};
        tbl[4] = '{sel: 1'b0, hb: 1, exp_done: 1'b1, exp_err: 1'b0, exp_locked: 1'b1, exp_cur: 1'b0, exp_full: 1'b1};
        tbl[5] = '{sel: 1'b0, hb: 4, exp_done: 1'b1, exp_err: 1'b0, exp_locked: 1'b1, exp_cur: 1'b0, exp_full: 1'b0};
        clear_flags();

        // Power-on check of the reset-selected clock.
        hb_per = 3;
        areset = 1'b1;
        repeat (3) tick();
        chk("reset selection", selection, RSEL);
        chk("reset req_ready", req_ready, 0);
        chk("reset switching", switching, 1);
        chk("reset locked", locked, 0);
        areset = 1'b0;
        clear_flags();
        wait_result(300, n);
        chk("poweron done", saw_done, 1);
        chk("poweron error", saw_err, 0);
        chk("poweron locked", locked, 1);
        chk("poweron req_ready", req_ready, 1);
        chk("poweron cur_sel", cur_sel, 0);

        // Switch 0 -> 1 with heartbeat present.
        request(1'b1);
        chk("switch selection at T+1", selection, 1);
        chk("switch locked at T+1", locked, 0);
        wait_result(SETTLE + TMO + 64, n);
        chk("switch done latency floor", (n >= SETTLE + HB), 1);
        chk("switch done", saw_done, 1);
        chk("switch cur_sel", cur_sel, 1);
        chk("switch locked", locked, 1);

        // Same-select fast path.
        request(1'b1);
        chk("fast done_pulse at T+1", done_pulse, 1);
        chk("fast switching", switching, 0);
        repeat (3) tick();
        chk("fast never switching", saw_sw, 0);
        chk("fast selection", selection, 1);

        for (int i = 0; i < 6; i++) begin
            hb_per = tbl[i].hb;
            request(tbl[i].sel);
            wait_result(SETTLE + TMO + 64, n);
            chk($sformatf("row%0d done", i), saw_done, tbl[i].exp_done);
            chk($sformatf("row%0d error", i), saw_err, tbl[i].exp_err);
            chk($sformatf("row%0d locked", i), locked, tbl[i].exp_locked);
            chk($sformatf("row%0d cur_sel", i), cur_sel, tbl[i].exp_cur);
            chk($sformatf("row%0d full sequence", i), saw_sw, tbl[i].exp_full);
        end

        // Stuck heartbeat: error exactly SETTLE+TMO-1 cycles after T+1.
        hb_per = 0;
        request(1'b1);
        wait_result(SETTLE + TMO + 64, n);
        chk("timeout cycle offset", n, SETTLE + TMO - 1);
        chk("timeout no done", saw_done, 0);
        chk("timeout error", saw_err, 1);
        chk("timeout locked", locked, 0);
        chk("timeout cur_sel", cur_sel, 1);

        // Retry of the same select after failure runs the full sequence.
        hb_per = 3;
        request(1'b1);
        wait_result(SETTLE + TMO + 64, n);
        chk("retry full sequence", saw_sw, 1);
        chk("retry done", saw_done, 1);
        chk("retry locked", locked, 1);

        // Reset in the middle of SETTLE aborts the switch.
        request(1'b0);
        wait_result(SETTLE + TMO + 64, n);
        request(1'b1);
        repeat (4) tick();
        clear_flags();
        areset = 1'b1;
        tick();
        chk("abort selection", selection, RSEL);
        repeat (2) tick();
        chk("abort no done", saw_done, 0);
        chk("abort no error", saw_err, 0);
        areset = 1'b0;
        clear_flags();
        wait_result(300, n);
        chk("abort reverify done", saw_done, 1);
        chk("abort reverify locked", locked, 1);
        chk("abort reverify cur_sel", cur_sel, RSEL);

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            areset    = ($urandom_range(0, 399) == 0);
            req_valid = ($urandom_range(0, 3) == 0);
            req_sel   = $urandom_range(0, 1);
            if ($urandom_range(0, 199) == 0) hb_per = $urandom_range(0, 4);
            tick();
        end
        areset    = 1'b0;
        req_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clkmux_select_ctrl.md
Name: clkmux_select_ctrl

Overview:
- Control-side companion to the team's BUFGMUX_1-based glitch-free clock mux wrapper.
- Runs on a free-running control clock and accepts clock-switch requests over a valid/ready handshake.
- Drives the mux `selection` line, waits a settle window, then confirms the muxed clock is alive by counting heartbeat toggles returned from the `aclk_out` domain.
- Reports lock, done or error to system control logic.

Parameters:
- SETTLE_CYCLES, 16: cycles to wait after a `selection` change before verification starts (range 1..65535).
- HB_EDGES, 4: heartbeat transitions required in VERIFY to declare lock (range 1..255).
- TIMEOUT_CYCLES, 1024: maximum cycles spent in VERIFY before an error is declared (must be greater than HB_EDGES).
- SYNC_STAGES, 2: flip-flop stages in the heartbeat synchronizer (range 2..4).
- RESET_SEL, 0: `selection` value driven during and after reset.

Ports:
- aclk  in  1  free-running control clock; all logic is on its rising edge.
- areset  in  1  synchronous reset, active-high.
- req_valid  in  1  switch request valid.
- req_sel  in  1  requested mux input (0 = I0, 1 = I1).
- req_ready  out  1  controller can accept a request.
- selection  out  1  registered select to the clock mux S pin.
- cur_sel  out  1  last selection for which verification completed (pass or fail).
- hb_toggle  in  1  asynchronous toggle generated in the muxed clock domain (flips every muxed-clock period or divided period).
- switching  out  1  high whenever state is not IDLE.
- locked  out  1  muxed clock verified alive on `cur_sel`.
- done_pulse  out  1  one-cycle pulse when a request or verification succeeds.
- error_pulse  out  1  one-cycle pulse when verification times out.

Behaviour:
- Reset (areset sampled high):
  - state = VERIFY; counters = 0; sync chain and edge register = 0.
  - selection = cur_sel = RESET_SEL.
  - locked = 0, req_ready = 0, done_pulse = 0, error_pulse = 0, switching = 1.
  - After release, the block immediately verifies the reset-selected clock. This is the power-on check.
- Heartbeat path:
  - `hb_toggle` passes through SYNC_STAGES flip-flops, then one edge register.
  - `hb_edge` = last synchronizer stage XOR edge register, so either transition counts.
  - Edges are counted only in VERIFY.
- IDLE:
  - req_ready = 1.
  - On `req_valid && req_ready`, same select (`req_sel == cur_sel`) and locked = 1: accept; done_pulse high on the next cycle; stay in IDLE; selection unchanged.
  - On `req_valid && req_ready` otherwise: `selection <= req_sel` on the next edge; locked <= 0; go to SETTLE with the settle counter = 0. This case covers a differing select, or any select when locked = 0 (retry after an error).
  - req_ready drops in the cycle after acceptance.
- SETTLE:
  - Settle counter increments every cycle.
  - After SETTLE_CYCLES cycles in SETTLE, go to VERIFY with the edge and timeout counters cleared.
  - Heartbeat edges in this window are ignored, since the old clock may still be toggling.
- VERIFY:
  - Timeout counter increments every cycle; edge counter increments on each hb_edge.
  - When the edge counter reaches HB_EDGES: go to IDLE; locked <= 1; cur_sel <= selection; done_pulse high for 1 cycle.
  - Otherwise, when the timeout counter reaches TIMEOUT_CYCLES-1: go to IDLE; locked <= 0; cur_sel <= selection; error_pulse high for 1 cycle.
  - If success and timeout occur in the same cycle, success wins.
- Latency for a switch accepted at cycle T:
  - selection changes at T+1.
  - VERIFY is entered at T+1+SETTLE_CYCLES.
  - done_pulse occurs no earlier than the cycle after the HB_EDGES-th synchronized edge.
- req_valid while req_ready = 0 is ignored. No request queueing; the requester holds valid until ready.
- areset mid-switch aborts unconditionally:
  - selection returns to RESET_SEL.
  - No done or error pulse is issued for the aborted request.
- done_pulse and error_pulse are never high together.
- Counter widths:
  - settle counter: $clog2(SETTLE_CYCLES+1).
  - edge counter: $clog2(HB_EDGES+1).
  - timeout counter: $clog2(TIMEOUT_CYCLES).
  - No wrap-around is possible, because every exit condition is an equality compare reached before overflow.

Test Plan:
1. Power-on, defaults, hb toggling every 3 aclk cycles:
   - During reset: selection = 0, req_ready = 0.
   - After release: done_pulse after 4 synced edges; locked = 1; req_ready = 1; cur_sel = 0.
2. Switch to 1 with heartbeat present (req_valid = 1, req_sel = 1 at cycle T):
   - selection = 1 at T+1; locked = 0 at T+1.
   - VERIFY at T+17.
   - done_pulse once 4 post-settle edges have been seen; cur_sel = 1; locked = 1.
3. Switch with hb_toggle held constant:
   - Stimulus: switch request at cycle T.
   - Response: error_pulse at T+17+1023; locked = 0; cur_sel = 1; done_pulse never asserted.
4. Same-select request while locked (req_sel = cur_sel):
   - done_pulse exactly 1 cycle after acceptance.
   - selection never toggles; switching stays 0.
5. Retry after failure:
   - After scenario 3, restore the heartbeat and request sel = 1 again.
   - Full SETTLE/VERIFY sequence runs (not the fast path); done_pulse; locked = 1.
6. areset asserted 5 cycles into SETTLE of a switch to 1:
   - selection = 0 on the next cycle.
   - No pulses from the aborted request.
   - Power-on verification then restarts and succeeds.
